// File: rtl/sevenseg_scan_driver.sv
// Multiplexed seven-segment scan driver: BCD decode, frame-boundary double buffering,
// per-slot dead-time, 4-bit brightness PWM and optional leading-zero blanking.
module sevenseg_scan_driver #(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned SCAN_DIV       = 12500,
    parameter int unsigned DEAD_CYCLES    = 64,
    parameter bit          COM_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [3:0]              brightness,
    input  logic                    lzb_en,
    output logic [7:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    frame_done
);

    localparam int unsigned SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);
    localparam int unsigned BCD_W  = 4 * NUM_DIGITS;

    logic [SLOT_W-1:0]     slot_q, slot_d;
    logic [IDX_W-1:0]      digit_q, digit_d;
    logic [3:0]            pwm_q;
    logic [BCD_W-1:0]      shadow_bcd_q, shadow_bcd_d, active_bcd_q, active_bcd_d;
    logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d, active_dp_q, active_dp_d;
    logic                  pending_q, pending_d;
    logic [7:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] dig_q, dig_d;
    logic                  frame_done_q;

    logic                  slot_wrap_c;
    logic                  boundary_c;
    logic                  dead_c;
    logic                  lit_c;
    logic                  lz_blank_c;
    logic [3:0]            cur_digit_c;
    logic [7:0]            pattern_c;
    logic [NUM_DIGITS-1:0] dig_on_c;

    // Scan counters and double-buffer transfer
    always_comb begin
        slot_wrap_c  = (slot_q == SLOT_W'(SCAN_DIV - 1));
        boundary_c   = slot_wrap_c && (digit_q == IDX_W'(NUM_DIGITS - 1));
        slot_d       = slot_wrap_c ? '0 : slot_q + SLOT_W'(1);
        digit_d      = digit_q;
        if (slot_wrap_c) begin
            digit_d = (digit_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_q + IDX_W'(1);
        end

        shadow_bcd_d = shadow_bcd_q;
        shadow_dp_d  = shadow_dp_q;
        active_bcd_d = active_bcd_q;
        active_dp_d  = active_dp_q;
        pending_d    = pending_q;
        if (load) begin
            shadow_bcd_d = bcd_in;
            shadow_dp_d  = dp_in;
        end
        if (boundary_c) begin
            pending_d = 1'b0;
            if (load) begin
                active_bcd_d = bcd_in;
                active_dp_d  = dp_in;
            end else if (pending_q) begin
                active_bcd_d = shadow_bcd_q;
                active_dp_d  = shadow_dp_q;
            end
        end else if (load) begin
            pending_d = 1'b1;
        end
    end

    // Segment decode, leading-zero blanking, dead-time and PWM gating
    always_comb begin
        cur_digit_c = active_bcd_q[{digit_q, 2'b00} +: 4];

        lz_blank_c = lzb_en && (digit_q != '0);
        for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
            if ((IDX_W'(j) >= digit_q) && (active_bcd_q[4*j +: 4] != 4'd0)) begin
                lz_blank_c = 1'b0;
            end
        end

        case (cur_digit_c)
            4'd0:    pattern_c = 8'hFC;
            4'd1:    pattern_c = 8'h60;
            4'd2:    pattern_c = 8'hDA;
            4'd3:    pattern_c = 8'hF2;
            4'd4:    pattern_c = 8'h66;
            4'd5:    pattern_c = 8'hB6;
            4'd6:    pattern_c = 8'hBE;
            4'd7:    pattern_c = 8'hE0;
            4'd8:    pattern_c = 8'hFE;
            4'd9:    pattern_c = 8'hF6;
            default: pattern_c = 8'h02;
        endcase

        dead_c = (slot_q < SLOT_W'(DEAD_CYCLES));
        lit_c  = !dead_c && ((brightness == 4'hF) || (pwm_q < brightness));

        seg_d    = 8'h00;
        dig_on_c = '0;
        if (lit_c) begin
            seg_d    = {(lz_blank_c ? 7'd0 : pattern_c[7:1]), active_dp_q[digit_q]};
            dig_on_c = NUM_DIGITS'(1) << digit_q;
        end
        dig_d = COM_ACTIVE_LOW ? ~dig_on_c : dig_on_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q       <= '0;
            digit_q      <= '0;
            pwm_q        <= 4'd0;
            shadow_bcd_q <= '0;
            shadow_dp_q  <= '0;
            active_bcd_q <= '0;
            active_dp_q  <= '0;
            pending_q    <= 1'b0;
            seg_q        <= 8'h00;
            dig_q        <= {NUM_DIGITS{COM_ACTIVE_LOW}};
            frame_done_q <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            digit_q      <= digit_d;
            pwm_q        <= pwm_q + 4'd1;
            shadow_bcd_q <= shadow_bcd_d;
            shadow_dp_q  <= shadow_dp_d;
            active_bcd_q <= active_bcd_d;
            active_dp_q  <= active_dp_d;
            pending_q    <= pending_d;
            seg_q        <= seg_d;
            dig_q        <= dig_d;
            frame_done_q <= boundary_c;
        end
    end

    assign seg_out    = seg_q;
    assign dig_en     = dig_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Scoreboard bench for sevenseg_scan_driver: a cycle-time model pushes the expected
// outputs for each counter state, popped and compared one clock later.
module tb_sevenseg_scan_driver;

    localparam int unsigned N     = 4;
    localparam int unsigned SDIV  = 16;
    localparam int unsigned DEAD  = 2;
    localparam int unsigned FRAME = N * SDIV;

    typedef struct packed {
        logic [7:0] seg;
        logic [3:0] dig;
        logic       fd;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic [15:0]  bcd_in;
    logic [3:0]   dp_in;
    logic [3:0]   brightness;
    logic         lzb_en;
    logic [7:0]   seg_out;
    logic [3:0]   dig_en;
    logic         frame_done;

    int           vectors    = 0;
    int           miscompares = 0;

    int unsigned  t;
    logic [15:0]  m_act, m_sh;
    logic [3:0]   m_act_dp, m_sh_dp;
    logic         m_pend;
    exp_t         sb[$];

    always #5 clk = ~clk;

    sevenseg_scan_driver #(
        .NUM_DIGITS(N), .SCAN_DIV(SDIV), .DEAD_CYCLES(DEAD), .COM_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
        .brightness(brightness), .lzb_en(lzb_en),
        .seg_out(seg_out), .dig_en(dig_en), .frame_done(frame_done)
    );

    function automatic logic [7:0] pat(input logic [3:0] d);
        case (d)
            4'd0: return 8'hFC;
            4'd1: return 8'h60;
            4'd2: return 8'hDA;
            4'd3: return 8'hF2;
            4'd4: return 8'h66;
            4'd5: return 8'hB6;
            4'd6: return 8'hBE;
            4'd7: return 8'hE0;
            4'd8: return 8'hFE;
            4'd9: return 8'hF6;
            default: return 8'h02;
        endcase
    endfunction

    // Counters all start at reset, and SCAN_DIV equals the PWM period, so pwm == slot here.
    function automatic exp_t expect_now();
        exp_t        e;
        int unsigned slot = t % SDIV;
        int unsigned d    = (t / SDIV) % N;
        int unsigned pwm  = t % 16;
        int unsigned msd  = 0;
        logic        lit;
        for (int unsigned k = 0; k < N; k++)
            if (m_act[4*k +: 4] != 4'd0) msd = k;
        lit  = (slot >= DEAD) && ((brightness == 4'hF) || (pwm < 32'(brightness)));
        e.fd = ((t % FRAME) == FRAME - 1);
        if (lit) begin
            e.dig = ~(4'b0001 << d);
            e.seg = ((lzb_en && d > msd) ? 8'h00 : pat(m_act[4*d +: 4])) | {7'd0, m_act_dp[d]};
        end else begin
            e.dig = 4'hF;
            e.seg = 8'h00;
        end
        return e;
    endfunction

    task automatic model_reset();
        t = 0; m_act = '0; m_sh = '0; m_act_dp = '0; m_sh_dp = '0; m_pend = 1'b0;
        sb.delete();
    endtask

    // Push expectation for the present state, advance model and DUT one clock, pop result.
    task automatic cycle(output exp_t e);
        logic bnd;
        sb.push_back(expect_now());
        bnd = ((t % FRAME) == FRAME - 1);
        if (bnd) begin
            if (load) begin m_act = bcd_in; m_act_dp = dp_in; end
            else if (m_pend) begin m_act = m_sh; m_act_dp = m_sh_dp; end
            m_pend = 1'b0;
        end else if (load) begin
            m_pend = 1'b1;
        end
        if (load) begin m_sh = bcd_in; m_sh_dp = dp_in; end
        t++;
        @(posedge clk);
        #1;
        e = sb.pop_front();
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1; load = 1'b0; bcd_in = '0; dp_in = '0; brightness = 4'hF; lzb_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({seg_out, dig_en, frame_done} !== {8'h00, 4'hF, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state got %h/%b/%b want 00/1111/0", seg_out, dig_en, frame_done);
        end
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < FRAME; i++) begin
            cycle(e);
            vectors++;
            if ({seg_out, dig_en, frame_done} !== e) begin
                miscompares++;
                $display("FAIL post_reset t=%0d got %h/%b/%b want %h/%b/%b",
                         t, seg_out, dig_en, frame_done, e.seg, e.dig, e.fd);
            end
        end
    endtask

    task automatic test_double_buffer();
        exp_t e;
        for (int i = 0; i < 150; i++) begin
            load = (i == 20); bcd_in = 16'h1234; dp_in = 4'b0000;
            cycle(e);
            load = 1'b0;
            vectors++;
            if ({seg_out, dig_en, frame_done} !== e) begin
                miscompares++;
                $display("FAIL double_buffer t=%0d got %h/%b/%b want %h/%b/%b",
                         t, seg_out, dig_en, frame_done, e.seg, e.dig, e.fd);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   ones = 0;
        bit   after = 1'b0;
        for (int i = 0; i < 140; i++) begin
            load   = (i == 5) || (i == 30);
            bcd_in = (i == 5) ? 16'h1111 : 16'h2222;
            cycle(e);
            load = 1'b0;
            vectors++;
            if ({seg_out, dig_en, frame_done} !== e) begin
                miscompares++;
                $display("FAIL back_to_back t=%0d got %h/%b/%b want %h/%b/%b",
                         t, seg_out, dig_en, frame_done, e.seg, e.dig, e.fd);
            end
            if (after && seg_out == 8'h60) ones++;
            if (e.fd) after = 1'b1;
        end
        vectors++;
        if (ones !== 0) begin
            miscompares++;
            $display("FAIL first_load_leaked got %0d cycles of 8'h60 want 0", ones);
        end
    endtask

    task automatic test_boundary_load();
        exp_t e;
        bit   done = 1'b0;
        for (int i = 0; i < 150; i++) begin
            load   = !done && ((t % FRAME) == FRAME - 1);
            bcd_in = 16'h0007; dp_in = 4'b0000;
            cycle(e);
            vectors++;
            if ({seg_out, dig_en, frame_done} !== e) begin
                miscompares++;
                $display("FAIL boundary_load t=%0d got %h/%b/%b want %h/%b/%b",
                         t, seg_out, dig_en, frame_done, e.seg, e.dig, e.fd);
            end
            if (load) begin
                done = 1'b1;
                vectors++;
                if (dut.pending_q !== 1'b0) begin
                    miscompares++;
                    $display("FAIL boundary_pending got %b want 0", dut.pending_q);
                end
            end
            load = 1'b0;
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL boundary_reached got 0 want 1");
        end
    endtask

    task automatic test_pwm();
        exp_t e;
        for (int i = 0; i < 2 * FRAME + FRAME; i++) begin
            brightness = (i < 2 * FRAME) ? 4'd4 : 4'd0;
            cycle(e);
            vectors++;
            if ({seg_out, dig_en, frame_done} !== e) begin
                miscompares++;
                $display("FAIL pwm br=%0d t=%0d got %h/%b/%b want %h/%b/%b",
                         brightness, t, seg_out, dig_en, frame_done, e.seg, e.dig, e.fd);
            end
        end
        brightness = 4'hF;
    endtask

    task automatic test_lzb();
        exp_t e;
        lzb_en = 1'b1;
        for (int i = 0; i < 280; i++) begin
            load   = (i == 3) || (i == 143);
            bcd_in = (i < 140) ? 16'h0050 : 16'h0000;
            dp_in  = (i < 140) ? 4'b1000 : 4'b0000;
            cycle(e);
            load = 1'b0;
            vectors++;
            if ({seg_out, dig_en, frame_done} !== e) begin
                miscompares++;
                $display("FAIL lzb t=%0d got %h/%b/%b want %h/%b/%b",
                         t, seg_out, dig_en, frame_done, e.seg, e.dig, e.fd);
            end
        end
        lzb_en = 1'b0;
    endtask

    task automatic test_dash_reset();
        exp_t e;
        for (int i = 0; i < 140; i++) begin
            load = (i == 2); bcd_in = 16'h000C; dp_in = 4'b0000;
            cycle(e);
            load = 1'b0;
            vectors++;
            if ({seg_out, dig_en, frame_done} !== e) begin
                miscompares++;
                $display("FAIL dash t=%0d got %h/%b/%b want %h/%b/%b",
                         t, seg_out, dig_en, frame_done, e.seg, e.dig, e.fd);
            end
        end
        for (int i = 0; i < SDIV && (t % SDIV) != 8; i++) cycle(e);
        rst = 1'b1;
        #1;
        vectors++;
        if ({seg_out, dig_en, frame_done} !== {8'h00, 4'hF, 1'b0}) begin
            miscompares++;
            $display("FAIL async_reset got %h/%b/%b want 00/1111/0", seg_out, dig_en, frame_done);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < FRAME + 8; i++) begin
            cycle(e);
            vectors++;
            if ({seg_out, dig_en, frame_done} !== e) begin
                miscompares++;
                $display("FAIL restart t=%0d got %h/%b/%b want %h/%b/%b",
                         t, seg_out, dig_en, frame_done, e.seg, e.dig, e.fd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_double_buffer();
        test_back_to_back();
        test_boundary_load();
        test_pwm();
        test_lzb();
        test_dash_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sevenseg_scan_driver.md
Name: sevenseg_scan_driver

Overview:
- Multiplexed seven-segment display driver; downstream of the BCD counter/decoder path on the Mojo board.
- Accepts packed BCD digits plus decimal points and decodes them to segments. Scans the common lines one digit at a time, with dead-time and 4-bit brightness PWM.
- Display updates are double-buffered and take effect only at frame boundaries, so digits never tear mid-frame.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (2..8).
- SCAN_DIV, 12500, clk cycles per digit slot (250 us at 50 MHz).
- DEAD_CYCLES, 64, blanked cycles at the start of each slot; 1 <= DEAD_CYCLES < SCAN_DIV.
- COM_ACTIVE_LOW, 1, 1 = dig_en bits are active-low; 0 = active-high.

Ports:
- clk  in  1  50 MHz system clock.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  single-cycle strobe; captures bcd_in/dp_in.
- bcd_in  in  4*NUM_DIGITS  packed BCD; bits [3:0] = digit 0 (rightmost, least significant).
- dp_in  in  NUM_DIGITS  decimal point per digit; bit i = digit i.
- brightness  in  4  0 = off, 15 = full on; sampled every cycle.
- lzb_en  in  1  leading-zero blanking enable.
- seg_out  out  8  {a,b,c,d,e,f,g,dp}, active-high, a = MSB.
- dig_en  out  NUM_DIGITS  digit common enables; polarity set by COM_ACTIVE_LOW.
- frame_done  out  1  one-cycle pulse when the last digit slot ends.

Behaviour:
- Reset (async, immediate):
  - seg_out = 0; dig_en = all inactive; frame_done = 0.
  - slot_cnt, digit_idx and pwm_cnt = 0.
  - Shadow and active digit/dp registers = 0; pending = 0.
- Double buffering:
  - On load, the shadow registers take bcd_in/dp_in and pending is set. A later load before the boundary overwrites the shadow (last load wins).
  - Boundary = the cycle where slot_cnt = SCAN_DIV-1 and digit_idx = NUM_DIGITS-1.
  - At the boundary, if pending: active <= shadow and pending is cleared.
  - If load coincides with the boundary: active <= bcd_in/dp_in directly, shadow is updated, pending stays 0.
- Scan counters:
  - slot_cnt counts 0..SCAN_DIV-1 and wraps.
  - On wrap, digit_idx increments; it wraps from NUM_DIGITS-1 to 0.
  - frame_done is registered high for exactly the cycle after the boundary.
- Dead-time: while slot_cnt < DEAD_CYCLES, all digits are inactive and seg_out = 0.
- PWM:
  - pwm_cnt is a free-running 4-bit counter on clk.
  - Outside dead-time, the digit is lit when brightness = 15 or pwm_cnt < brightness; otherwise outputs are as in dead-time.
  - Duty is therefore brightness/16, except 15 = 100%.
- Decode:
  - 0..9 → a..g patterns {FC,60,DA,F2,66,B6,BE,E0,FE,F6} with dp cleared.
  - 10..15 → 8'h02 (dash, segment g only).
  - dp bit (LSB) = dp_in bit of the current digit; it is ORed after blanking.
- Leading-zero blanking (lzb_en = 1):
  - Scanning from the most significant digit downward, zero digits are blanked (a..g = 0) until the first nonzero digit.
  - Digit 0 is never blanked; a blanked digit still shows its dp.
  - Non-BCD digits count as nonzero.
- Active digit: exactly one dig_en bit is active (digit_idx) when lit; never more than one.
- Latency: seg_out and dig_en are registered, one cycle after the counter state that selects them. Both change in the same cycle.
- Simultaneous events:
  - brightness changes apply on the next cycle.
  - lzb_en changes apply combinationally to the next registered output.
  - rst during a slot aborts it; the scan restarts at digit 0, slot 0.

Test Plan (SCAN_DIV=16, DEAD_CYCLES=2, NUM_DIGITS=4, COM_ACTIVE_LOW=1):
1. Reset, then load bcd_in=16'h1234, dp_in=0, brightness=15 mid-frame.
   - Outputs still show 0000 until frame_done.
   - Next frame: digit 0 slot gives dig_en=4'b1110 with seg_out=8'h66 (4); digit 3 gives 4'b0111 with 8'h60 (1).
   - Each slot has 2 blank cycles then 14 lit cycles.
2. Two loads in one frame (16'h1111 then 16'h2222).
   - Only 2222 is displayed next frame; 1111 never appears on seg_out.
3. Load 16'h0007 coinciding with the boundary cycle.
   - 7 (8'hE0) is shown in the very next digit-0 slot; pending=0.
4. brightness=4.
   - Within each lit slot window, outputs are lit exactly when pwm_cnt in 0..3 (4 of every 16 cycles).
   - brightness=0 gives seg_out=0 and dig_en=4'b1111 continuously.
5. lzb_en=1, bcd_in=16'h0050, dp_in=4'b1000.
   - Digit 3 shows 8'h01 (dp only); digit 2 shows 8'h00.
   - Digit 1 shows 8'hB6; digit 0 shows 8'hFC.
   - bcd_in=0 shows only digit 0 as 8'hFC.
6. Digit value 4'hC shows 8'h02. Assert rst mid-slot.
   - Outputs go inactive immediately.
   - After release, scan restarts at digit 0 with display 0000.
